// File: rtl/mant_sub_norm.sv
// mant_sub_norm: sequential mantissa subtract-and-normalize unit.
// Computes |a-b| and its sign, then left-normalizes the magnitude so that
// its MSB is set, and reports the shift count for exponent adjustment.
// Build option: MANT_SUB_NORM_FAST_EN selects single-cycle normalization
// through a leading-zero priority encoder. When it is undefined, the unit
// normalizes iteratively at one bit per cycle.
module mant_sub_norm #(
    parameter int WIDTH = 22,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             sign,
    output logic [SW-1:0]    shift,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_n;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] diff_r;
    logic             sign_r;
    logic [SW-1:0]    shift_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] neg_s;
    logic             work_zero_s;
    logic             norm_done_s;

    // The borrow out of the extended subtraction is the result sign.
    assign sub_s       = {1'b0, a_r} - {1'b0, b_r};
    assign neg_s       = b_r - a_r;
    assign work_zero_s = (work_r == {WIDTH{1'b0}});

`ifdef MANT_SUB_NORM_FAST_EN
    logic [SW-1:0]    lz_s;
    logic [WIDTH-1:0] norm_s;

    // Count the leading zeros of a non-zero vector. The caller handles an
    // all-zero input separately.
    function automatic logic [SW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
        logic [SW-1:0] n;
        logic          found;
        n     = {SW{1'b0}};
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + SW'(1);
                end
            end
        end
        return n;
    endfunction

    assign lz_s        = lead_zeros(work_r);
    assign norm_s      = work_r << lz_s;
    assign norm_done_s = 1'b1;
`else
    assign norm_done_s = work_zero_s || work_r[WIDTH-1];
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic. An operand is accepted only in IDLE, and a result is
    // released only in DONE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_n = ST_SUB;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SUB: begin
                state_n = ST_NORM;
            end
            ST_NORM: begin
                if (norm_done_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_NORM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture, subtract, and normalize. The handshake flags are
    // registered from the next state so that each flag is a clean flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            work_r      <= {WIDTH{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            sign_r      <= 1'b0;
            shift_r     <= {SW{1'b0}};
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                ST_SUB: begin
                    sign_r  <= sub_s[WIDTH];
                    work_r  <= sub_s[WIDTH] ? neg_s : sub_s[WIDTH-1:0];
                    shift_r <= {SW{1'b0}};
                    zero_r  <= 1'b0;
                end
                ST_NORM: begin
                    if (work_zero_s) begin
                        zero_r  <= 1'b1;
                        sign_r  <= 1'b0;
                        diff_r  <= {WIDTH{1'b0}};
                        shift_r <= {SW{1'b0}};
`ifdef MANT_SUB_NORM_FAST_EN
                    end else begin
                        diff_r  <= norm_s;
                        work_r  <= norm_s;
                        shift_r <= lz_s;
                    end
`else
                    end else if (work_r[WIDTH-1]) begin
                        diff_r <= work_r;
                    end else begin
                        work_r  <= {work_r[WIDTH-2:0], 1'b0};
                        shift_r <= shift_r + SW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    diff_r <= diff_r;
                end
                default: begin
                    work_r <= {WIDTH{1'b0}};
                end
            endcase
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign sign      = sign_r;
    assign shift     = shift_r;
    assign zero      = zero_r;

endmodule
